// File: rtl/victim_cache_pkg.sv
// Shared types for the victim cache and its age tracker.
//   lc3b_word      - 16-bit line address
//   lc3b_cacheline - 128-bit line payload
//   lc3b_vc_tag    - 12-bit tag (address bits [15:4])
//   lc3b_vc_idx    - 2-bit entry index / age
//   vc_state_e     - controller states
package victim_cache_pkg;

    localparam int VC_ENTRIES = 4;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_cacheline;
    typedef logic [11:0]  lc3b_vc_tag;
    typedef logic [1:0]   lc3b_vc_idx;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESP,
        ST_L2_READ,
        ST_L2_WB
    } vc_state_e;

endpackage

// File: rtl/victim_lru.sv
// Age tracker for the four victim-cache entries (0 = MRU, 3 = LRU).
// Ports:
//   clk, rst_n           - clock, async active-low reset (ages reset to index)
//   touch_en, touch_idx  - make touch_idx the MRU entry this cycle
//   valid, dirty         - current entry state, used for the update and search
//   lru_idx              - entry whose age is 3
//   clean_idx            - oldest valid clean entry, meaningful when clean_found
module victim_lru
    import victim_cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  touch_en,
    input  lc3b_vc_idx            touch_idx,
    input  logic [VC_ENTRIES-1:0] valid,
    input  logic [VC_ENTRIES-1:0] dirty,
    output lc3b_vc_idx            lru_idx,
    output lc3b_vc_idx            clean_idx,
    output logic                  clean_found
);

    lc3b_vc_idx age_q [VC_ENTRIES];
    lc3b_vc_idx age_d [VC_ENTRIES];
    lc3b_vc_idx threshold;
    lc3b_vc_idx best_age;

    // Installing into an invalid entry ages every valid entry; touching a
    // valid entry only ages those younger than it, keeping a permutation.
    always_comb begin
        age_d     = age_q;
        threshold = valid[touch_idx] ? age_q[touch_idx] : 2'd3;
        if (touch_en) begin
            for (int i = 0; i < VC_ENTRIES; i++) begin
                if (valid[i] && (age_q[i] < threshold)) begin
                    age_d[i] = age_q[i] + 2'd1;
                end
            end
            age_d[touch_idx] = 2'd0;
        end
    end

    always_comb begin
        lru_idx     = '0;
        clean_idx   = '0;
        clean_found = 1'b0;
        best_age    = '0;
        for (int i = 0; i < VC_ENTRIES; i++) begin
            if (age_q[i] == 2'd3) begin
                lru_idx = lc3b_vc_idx'(i);
            end
            if (valid[i] && !dirty[i] && (!clean_found || (age_q[i] > best_age))) begin
                clean_found = 1'b1;
                clean_idx   = lc3b_vc_idx'(i);
                best_age    = age_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < VC_ENTRIES; i++) begin
                age_q[i] <= lc3b_vc_idx'(i);
            end
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/victim_cache.sv
// Four-entry fully associative victim cache between L1 and L2.
// Ports:
//   mem_read/mem_write/mem_evict, mem_address, mem_wdata - L1 requests
//   mem_rdata, mem_resp                                  - L1 completion
//   l2_read/l2_write, l2_address, l2_wdata               - L2 requests
//   l2_rdata, l2_resp                                    - L2 completion
//   vc_hit_inc, vc_miss_inc                              - per-request counters
module victim_cache
    import victim_cache_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic          mem_evict,
    input  lc3b_word      mem_address,
    input  lc3b_cacheline mem_wdata,
    output lc3b_cacheline mem_rdata,
    output logic          mem_resp,
    output logic          l2_read,
    output logic          l2_write,
    output lc3b_word      l2_address,
    output lc3b_cacheline l2_wdata,
    input  lc3b_cacheline l2_rdata,
    input  logic          l2_resp,
    output logic          vc_hit_inc,
    output logic          vc_miss_inc
);

    vc_state_e             state_q, state_d;
    logic [VC_ENTRIES-1:0] valid_q, valid_d;
    logic [VC_ENTRIES-1:0] dirty_q, dirty_d;
    lc3b_vc_tag            tag_q  [VC_ENTRIES];
    lc3b_vc_tag            tag_d  [VC_ENTRIES];
    lc3b_cacheline         data_q [VC_ENTRIES];
    lc3b_cacheline         data_d [VC_ENTRIES];
    lc3b_cacheline         rdata_q, rdata_d;
    lc3b_vc_idx            target_q, target_d;

    lc3b_vc_tag req_tag;
    logic       hit, inv_found, clean_found, touch_en;
    lc3b_vc_idx hit_idx, inv_idx, lru_idx, clean_idx, touch_idx, wr_idx;

    assign req_tag = mem_address[15:4];

    always_comb begin
        hit       = 1'b0;
        hit_idx   = '0;
        inv_found = 1'b0;
        inv_idx   = '0;
        for (int i = VC_ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && (tag_q[i] == req_tag)) begin
                hit     = 1'b1;
                hit_idx = lc3b_vc_idx'(i);
            end
            if (!valid_q[i]) begin
                inv_found = 1'b1;
                inv_idx   = lc3b_vc_idx'(i);
            end
        end
    end

    victim_lru u_lru (
        .clk         (clk),
        .rst_n       (rst_n),
        .touch_en    (touch_en),
        .touch_idx   (touch_idx),
        .valid       (valid_q),
        .dirty       (dirty_q),
        .lru_idx     (lru_idx),
        .clean_idx   (clean_idx),
        .clean_found (clean_found)
    );

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        tag_d       = tag_q;
        data_d      = data_q;
        rdata_d     = rdata_q;
        target_d    = target_q;
        touch_en    = 1'b0;
        touch_idx   = '0;
        wr_idx      = inv_found ? inv_idx : lru_idx;
        vc_hit_inc  = 1'b0;
        vc_miss_inc = 1'b0;
        mem_resp    = 1'b0;
        l2_read     = 1'b0;
        l2_write    = 1'b0;
        l2_address  = '0;
        l2_wdata    = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (mem_evict) begin
                    if (hit) begin
                        data_d[hit_idx] = mem_wdata;
                        touch_en        = 1'b1;
                        touch_idx       = hit_idx;
                    end else if (inv_found || clean_found) begin
                        // A clean line dropped when all entries are dirty
                        // loses nothing, so that case simply falls through.
                        touch_idx          = inv_found ? inv_idx : clean_idx;
                        touch_en           = 1'b1;
                        valid_d[touch_idx] = 1'b1;
                        dirty_d[touch_idx] = 1'b0;
                        tag_d[touch_idx]   = req_tag;
                        data_d[touch_idx]  = mem_wdata;
                    end
                end else if (mem_read && !mem_write) begin
                    if (hit) begin
                        rdata_d    = data_q[hit_idx];
                        touch_en   = 1'b1;
                        touch_idx  = hit_idx;
                        vc_hit_inc = 1'b1;
                        state_d    = ST_RESP;
                    end else begin
                        vc_miss_inc = 1'b1;
                        state_d     = ST_L2_READ;
                    end
                end else if (mem_write && !mem_read) begin
                    if (hit) begin
                        data_d[hit_idx]  = mem_wdata;
                        dirty_d[hit_idx] = 1'b1;
                        touch_en         = 1'b1;
                        touch_idx        = hit_idx;
                        vc_hit_inc       = 1'b1;
                        state_d          = ST_RESP;
                    end else begin
                        vc_miss_inc = 1'b1;
                        if (valid_q[wr_idx] && dirty_q[wr_idx]) begin
                            target_d = wr_idx;
                            state_d  = ST_L2_WB;
                        end else begin
                            valid_d[wr_idx] = 1'b1;
                            dirty_d[wr_idx] = 1'b1;
                            tag_d[wr_idx]   = req_tag;
                            data_d[wr_idx]  = mem_wdata;
                            touch_en        = 1'b1;
                            touch_idx       = wr_idx;
                            state_d         = ST_RESP;
                        end
                    end
                end
            end
            ST_L2_WB: begin
                l2_write   = 1'b1;
                l2_address = {tag_q[target_q], 4'b0000};
                l2_wdata   = data_q[target_q];
                if (l2_resp) begin
                    // The requester holds address and data, so the pending
                    // line is taken straight from the L1 inputs.
                    dirty_d[target_q] = 1'b1;
                    tag_d[target_q]   = req_tag;
                    data_d[target_q]  = mem_wdata;
                    touch_en          = 1'b1;
                    touch_idx         = target_q;
                    state_d           = ST_RESP;
                end
            end
            ST_L2_READ: begin
                l2_read    = 1'b1;
                l2_address = mem_address;
                if (l2_resp) begin
                    rdata_d = l2_rdata;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                mem_resp = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_rdata = rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            valid_q  <= '0;
            dirty_q  <= '0;
            rdata_q  <= '0;
            target_q <= '0;
            for (int i = 0; i < VC_ENTRIES; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            dirty_q  <= dirty_d;
            rdata_q  <= rdata_d;
            target_q <= target_d;
            tag_q    <= tag_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: tb/tb_victim_cache.sv
module tb_victim_cache;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         mem_read = 1'b0, mem_write = 1'b0, mem_evict = 1'b0;
    logic [15:0]  mem_address = '0;
    logic [127:0] mem_wdata = '0;
    logic [127:0] mem_rdata;
    logic         mem_resp;
    logic         l2_read, l2_write;
    logic [15:0]  l2_address;
    logic [127:0] l2_wdata;
    logic [127:0] l2_rdata = '0;
    logic         l2_resp = 1'b0;
    logic         vc_hit_inc, vc_miss_inc;

    int n_cmp = 0;
    int n_err = 0;

    victim_cache dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_evict   (mem_evict),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_resp    (mem_resp),
        .l2_read     (l2_read),
        .l2_write    (l2_write),
        .l2_address  (l2_address),
        .l2_wdata    (l2_wdata),
        .l2_rdata    (l2_rdata),
        .l2_resp     (l2_resp),
        .vc_hit_inc  (vc_hit_inc),
        .vc_miss_inc (vc_miss_inc)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: per-slot contents plus a recency list (MRU first).
    logic         m_valid [4];
    logic         m_dirty [4];
    logic [11:0]  m_tag   [4];
    logic [127:0] m_data  [4];
    int           m_order [$];

    function automatic void m_reset();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = '0;
            m_data[i]  = '0;
        end
        m_order.delete();
    endfunction

    function automatic int m_find(input logic [11:0] t);
        for (int i = 0; i < 4; i++)
            if (m_valid[i] && m_tag[i] == t) return i;
        return -1;
    endfunction

    function automatic int m_first_invalid();
        for (int i = 0; i < 4; i++)
            if (!m_valid[i]) return i;
        return -1;
    endfunction

    function automatic int m_oldest_clean();
        for (int k = m_order.size() - 1; k >= 0; k--)
            if (!m_dirty[m_order[k]]) return m_order[k];
        return -1;
    endfunction

    function automatic void m_touch(input int idx);
        for (int k = 0; k < m_order.size(); k++) begin
            if (m_order[k] == idx) begin
                m_order.delete(k);
                break;
            end
        end
        m_order.push_front(idx);
    endfunction

    function automatic void m_install(input int idx, input logic [11:0] t,
                                      input logic [127:0] d, input logic dty);
        m_valid[idx] = 1'b1;
        m_dirty[idx] = dty;
        m_tag[idx]   = t;
        m_data[idx]  = d;
        m_touch(idx);
    endfunction

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; mem_evict = 1'b0; l2_resp = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        @(negedge clk);
    endtask

    task automatic do_evict(input logic [15:0] addr, input logic [127:0] d);
        int idx, tgt;
        mem_evict = 1'b1; mem_address = addr; mem_wdata = d;
        #1;
        n_cmp++;
        if (vc_hit_inc !== 1'b0 || vc_miss_inc !== 1'b0) begin
            n_err++;
            $display("FAIL evict_counters: hit=%b miss=%b, want 0/0", vc_hit_inc, vc_miss_inc);
        end
        @(negedge clk);
        mem_evict = 1'b0;
        idx = m_find(addr[15:4]);
        if (idx >= 0) begin
            m_data[idx] = d;
            m_touch(idx);
        end else begin
            tgt = m_first_invalid();
            if (tgt < 0) tgt = m_oldest_clean();
            if (tgt >= 0) m_install(tgt, addr[15:4], d, 1'b0);
        end
    endtask

    task automatic do_read(input logic [15:0] addr);
        int idx, lat;
        logic [127:0] exp_d;
        idx = m_find(addr[15:4]);
        mem_read = 1'b1; mem_address = addr;
        #1;
        n_cmp++;
        if (vc_hit_inc !== 1'(idx >= 0) || vc_miss_inc !== 1'(idx < 0)) begin
            n_err++;
            $display("FAIL rd_counters addr=%h: hit=%b miss=%b, want %b/%b",
                     addr, vc_hit_inc, vc_miss_inc, idx >= 0, idx < 0);
        end
        @(negedge clk);
        if (idx >= 0) begin
            exp_d = m_data[idx];
            m_touch(idx);
        end else begin
            n_cmp++;
            if (l2_read !== 1'b1 || l2_address !== addr || l2_write !== 1'b0) begin
                n_err++;
                $display("FAIL rd_l2_req: l2_read=%b l2_write=%b l2_address=%h, want 1/0/%h",
                         l2_read, l2_write, l2_address, addr);
            end
            lat = $urandom_range(0, 2);
            repeat (lat) @(negedge clk);
            exp_d = rand_line();
            l2_rdata = exp_d;
            l2_resp = 1'b1;
            @(negedge clk);
            l2_resp = 1'b0;
        end
        n_cmp++;
        if (mem_resp !== 1'b1 || mem_rdata !== exp_d || l2_read !== 1'b0 ||
            vc_hit_inc !== 1'b0 || vc_miss_inc !== 1'b0) begin
            n_err++;
            $display("FAIL rd_resp addr=%h: resp=%b l2_read=%b inc=%b%b rdata=%h, want 1/0/00 %h",
                     addr, mem_resp, l2_read, vc_hit_inc, vc_miss_inc, mem_rdata, exp_d);
        end
        mem_read = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (mem_resp !== 1'b0) begin
            n_err++;
            $display("FAIL rd_resp_width: mem_resp=%b one cycle after response, want 0", mem_resp);
        end
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [127:0] d);
        int idx, tgt, lat;
        idx = m_find(addr[15:4]);
        mem_write = 1'b1; mem_address = addr; mem_wdata = d;
        #1;
        n_cmp++;
        if (vc_hit_inc !== 1'(idx >= 0) || vc_miss_inc !== 1'(idx < 0)) begin
            n_err++;
            $display("FAIL wr_counters addr=%h: hit=%b miss=%b, want %b/%b",
                     addr, vc_hit_inc, vc_miss_inc, idx >= 0, idx < 0);
        end
        @(negedge clk);
        if (idx >= 0) begin
            m_data[idx]  = d;
            m_dirty[idx] = 1'b1;
            m_touch(idx);
        end else begin
            tgt = m_first_invalid();
            if (tgt < 0) tgt = m_order[m_order.size() - 1];
            if (m_valid[tgt] && m_dirty[tgt]) begin
                n_cmp++;
                if (l2_write !== 1'b1 || l2_read !== 1'b0 ||
                    l2_address !== {m_tag[tgt], 4'h0} || l2_wdata !== m_data[tgt]) begin
                    n_err++;
                    $display("FAIL wr_l2_wb: l2_write=%b l2_address=%h l2_wdata=%h, want 1/%h/%h",
                             l2_write, l2_address, l2_wdata, {m_tag[tgt], 4'h0}, m_data[tgt]);
                end
                lat = $urandom_range(0, 2);
                repeat (lat) @(negedge clk);
                l2_resp = 1'b1;
                @(negedge clk);
                l2_resp = 1'b0;
            end
            m_install(tgt, addr[15:4], d, 1'b1);
        end
        n_cmp++;
        if (mem_resp !== 1'b1 || l2_write !== 1'b0 || l2_read !== 1'b0) begin
            n_err++;
            $display("FAIL wr_resp addr=%h: resp=%b l2_write=%b l2_read=%b, want 1/0/0",
                     addr, mem_resp, l2_write, l2_read);
        end
        mem_write = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (mem_resp !== 1'b0) begin
            n_err++;
            $display("FAIL wr_resp_width: mem_resp=%b one cycle after response, want 0", mem_resp);
        end
    endtask

    task automatic do_conflict(input logic [15:0] addr);
        mem_read = 1'b1; mem_write = 1'b1; mem_address = addr; mem_wdata = rand_line();
        #1;
        n_cmp++;
        if (vc_hit_inc !== 1'b0 || vc_miss_inc !== 1'b0) begin
            n_err++;
            $display("FAIL conflict_counters: hit=%b miss=%b, want 0/0", vc_hit_inc, vc_miss_inc);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (mem_resp !== 1'b0 || l2_read !== 1'b0 || l2_write !== 1'b0) begin
            n_err++;
            $display("FAIL conflict_ignored: resp=%b l2_read=%b l2_write=%b, want 0/0/0",
                     mem_resp, l2_read, l2_write);
        end
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if (mem_resp !== 1'b0 || mem_rdata !== '0 || l2_read !== 1'b0 || l2_write !== 1'b0 ||
            l2_address !== '0 || l2_wdata !== '0 || vc_hit_inc !== 1'b0 || vc_miss_inc !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: resp=%b rdata=%h l2r=%b l2w=%b l2a=%h l2wd=%h inc=%b%b, want all 0",
                     mem_resp, mem_rdata, l2_read, l2_write, l2_address, l2_wdata,
                     vc_hit_inc, vc_miss_inc);
        end
    endtask

    task automatic test_evict_then_read();
        apply_reset();
        do_evict(16'h1230, rand_line());
        do_read(16'h1238);
    endtask

    task automatic test_read_miss();
        apply_reset();
        do_read(16'h4000);
        do_read(16'h4000);
    endtask

    task automatic test_dirty_displace();
        apply_reset();
        do_write(16'h1000, rand_line());
        do_write(16'h2000, rand_line());
        do_write(16'h3000, rand_line());
        do_write(16'h4000, rand_line());
        do_write(16'h5000, rand_line());
        do_read(16'h5000);
    endtask

    task automatic test_evict_drop();
        // Continues from a cache full of dirty lines.
        do_evict(16'h6000, rand_line());
        do_read(16'h6000);
        do_read(16'h2000);
        do_read(16'h3000);
        do_read(16'h4000);
        do_read(16'h5000);
    endtask

    task automatic test_evict_keeps_dirty();
        logic [127:0] c;
        c = rand_line();
        apply_reset();
        do_write(16'h1000, c);
        do_evict(16'h1000, c);
        do_write(16'h2000, rand_line());
        do_write(16'h3000, rand_line());
        do_write(16'h4000, rand_line());
        do_write(16'h5000, rand_line());
    endtask

    task automatic test_reset_mid_l2();
        apply_reset();
        do_write(16'h7000, rand_line());
        do_evict(16'h8000, rand_line());
        mem_read = 1'b1; mem_address = 16'h9000;
        @(negedge clk);
        n_cmp++;
        if (l2_read !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset_pre: l2_read=%b, want 1", l2_read);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (l2_read !== 1'b0 || l2_address !== '0 || mem_resp !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_drop: l2_read=%b l2_address=%h resp=%b, want 0/0/0",
                     l2_read, l2_address, mem_resp);
        end
        mem_read = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        @(negedge clk);
        do_read(16'h7000);
        do_read(16'h8000);
    endtask

    task automatic test_conflict();
        apply_reset();
        do_write(16'h1000, rand_line());
        do_conflict(16'h1000);
        do_conflict(16'h2000);
        do_read(16'h1000);
    endtask

    task automatic test_random();
        logic [15:0] addr;
        int op;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            addr = {12'h100 + 12'($urandom_range(0, 6)), 4'($urandom)};
            op = $urandom_range(0, 9);
            if (op <= 2)      do_evict(addr, rand_line());
            else if (op <= 5) do_read(addr);
            else if (op <= 8) do_write(addr, rand_line());
            else              do_conflict(addr);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
    endtask

    initial begin
        m_reset();
        @(negedge clk);
        test_reset();
        test_evict_then_read();
        test_read_miss();
        test_dirty_displace();
        test_evict_drop();
        test_evict_keeps_dirty();
        test_reset_mid_l2();
        test_conflict();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
